// File: rtl/bg_scroll_ctrl.sv
// Background scroll controller: moves a VIS_W x VIS_H window over a BG_W x BG_H
// bitmap once per frame tick, freezes after a collision, then recenters.
// Optional feature macro: BG_SCROLL_DIAG_EN (diagonal / multi-bit direction).
module bg_scroll_ctrl #(
    parameter int unsigned BG_W          = 960,
    parameter int unsigned BG_H          = 720,
    parameter int unsigned VIS_W         = 640,
    parameter int unsigned VIS_H         = 480,
    parameter int unsigned STEP          = 1,
    parameter int unsigned FREEZE_FRAMES = 60
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       frame_clk,
    input  logic [3:0] direction,
    input  logic       collided,
    output logic [9:0] x_offset,
    output logic [9:0] y_offset,
    output logic       frozen,
    output logic       offset_upd
);

    localparam logic [10:0] XMAX   = 11'(BG_W - VIS_W);
    localparam logic [10:0] YMAX   = 11'(BG_H - VIS_H);
    localparam logic [9:0]  XCTR   = 10'((BG_W - VIS_W) / 2);
    localparam logic [9:0]  YCTR   = 10'((BG_H - VIS_H) / 2);
    localparam logic [10:0] STEP11 = 11'(STEP);
    localparam logic [7:0]  FRZ    = 8'(FREEZE_FRAMES);

    typedef enum logic [1:0] {StRun, StFreeze, StRecenter} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic        upd_q, upd_d;
    logic        sync1_q, sync2_q, edge_q;
    logic        tick;
    logic        mv_up, mv_dn, mv_rt, mv_lf;
    logic [10:0] x_new, y_new;

    // One axis step with clamping to [0, maxv]; 11 bits so the add never wraps.
    function automatic logic [10:0] step_axis(input logic [10:0] cur, input logic inc,
                                              input logic dec, input logic [10:0] maxv);
        logic [10:0] sum;
        sum = cur + STEP11;
        if (inc) begin
            return (sum > maxv) ? maxv : sum;
        end else if (dec) begin
            return (cur < STEP11) ? 11'd0 : cur - STEP11;
        end
        return cur;
    endfunction

    // Two-flop synchronizer plus edge flop for the asynchronous frame tick.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    assign tick = sync2_q & ~edge_q;

    // Direction decode into per-axis move requests.
    always_comb begin
`ifdef BG_SCROLL_DIAG_EN
        // Each bit acts independently; opposing bits cancel on their axis.
        mv_up = direction[3] & ~direction[2];
        mv_dn = direction[2] & ~direction[3];
        mv_rt = direction[1] & ~direction[0];
        mv_lf = direction[0] & ~direction[1];
`else
        // Only a single set bit moves; anything else is treated as idle.
        mv_up = direction[3] & $onehot(direction);
        mv_dn = direction[2] & $onehot(direction);
        mv_rt = direction[1] & $onehot(direction);
        mv_lf = direction[0] & $onehot(direction);
`endif
    end

    assign x_new = step_axis({1'b0, x_q}, mv_rt, mv_lf, XMAX);
    assign y_new = step_axis({1'b0, y_q}, mv_dn, mv_up, YMAX);

    // Next-state and next-offset logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        upd_d   = 1'b0;
        unique case (state_q)
            StRun: begin
                if (collided) begin
                    // Movement of a coincident tick is discarded.
                    state_d = StFreeze;
                    cnt_d   = FRZ;
                end else if (tick) begin
                    x_d   = x_new[9:0];
                    y_d   = y_new[9:0];
                    upd_d = (x_new[9:0] != x_q) || (y_new[9:0] != y_q);
                end
            end
            StFreeze: begin
                if (tick) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        cnt_d   = 8'd0;
                        state_d = StRecenter;
                    end
                end
            end
            StRecenter: begin
                // A still-high collided is picked up by RUN on the following cycle.
                if (tick) begin
                    x_d     = XCTR;
                    y_d     = YCTR;
                    upd_d   = 1'b1;
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // State, counter and offset registers.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state_q <= StRun;
            cnt_q   <= 8'd0;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            upd_q   <= upd_d;
        end
    end

    assign x_offset   = x_q;
    assign y_offset   = y_q;
    assign offset_upd = upd_q;
    assign frozen     = (state_q == StFreeze);

endmodule

// File: tb/tb_bg_scroll_ctrl.sv
// Directed bench for bg_scroll_ctrl (default geometry, FREEZE_FRAMES = 3).
module tb_bg_scroll_ctrl;

    logic       vga_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic [3:0] direction = 4'b0000;
    logic       collided = 1'b0;
    logic [9:0] x_offset, y_offset;
    logic       frozen, offset_upd;

    int vectors = 0;
    int fails   = 0;
    int upd_total = 0;
    int base;

    bg_scroll_ctrl #(
        .BG_W(960), .BG_H(720), .VIS_W(640), .VIS_H(480),
        .STEP(1), .FREEZE_FRAMES(3)
    ) dut (
        .vga_clk   (vga_clk),
        .reset_n   (reset_n),
        .frame_clk (frame_clk),
        .direction (direction),
        .collided  (collided),
        .x_offset  (x_offset),
        .y_offset  (y_offset),
        .frozen    (frozen),
        .offset_upd(offset_upd)
    );

    always #5 vga_clk = ~vga_clk;

    // Running count of offset_upd pulses, sampled mid-cycle.
    always @(negedge vga_clk) if (offset_upd === 1'b1) upd_total <= upd_total + 1;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge vga_clk);
        #1;
    endtask

    task automatic frame(input int n);
        repeat (n) begin
            frame_clk = 1'b1;
            cyc(5);
            frame_clk = 1'b0;
            cyc(5);
        end
    endtask

    initial begin
        // Reset state
        cyc(3);
        check("rst_x", 16'(x_offset), 16'd0);
        check("rst_y", 16'(y_offset), 16'd0);
        check("rst_frozen", 16'(frozen), 16'd0);
        check("rst_upd", 16'(offset_upd), 16'd0);
        reset_n = 1'b1;
        cyc(2);

        // Left at x = 0 clamps, no pulse
        base = upd_total;
        direction = 4'b0001;
        frame(1);
        check("left_clamp_x", 16'(x_offset), 16'd0);
        check("left_clamp_upd", 16'(upd_total - base), 16'd0);

        // Ten ticks right
        base = upd_total;
        direction = 4'b0010;
        frame(10);
        check("right10_x", 16'(x_offset), 16'd10);
        check("right10_y", 16'(y_offset), 16'd0);
        check("right10_upd", 16'(upd_total - base), 16'd10);

        // Idle direction holds
        base = upd_total;
        direction = 4'b0000;
        frame(2);
        check("idle_x", 16'(x_offset), 16'd10);
        check("idle_upd", 16'(upd_total - base), 16'd0);

        // Down to 239, then 3 more ticks clamp at 240
        direction = 4'b0100;
        frame(239);
        check("down239_y", 16'(y_offset), 16'd239);
        base = upd_total;
        frame(3);
        check("down_clamp_y", 16'(y_offset), 16'd240);
        check("down_clamp_upd", 16'(upd_total - base), 16'd1);

        // Move to (5,5) then apply up+right together
        direction = 4'b0001;
        frame(5);
        direction = 4'b1000;
        frame(235);
        check("pre_diag_x", 16'(x_offset), 16'd5);
        check("pre_diag_y", 16'(y_offset), 16'd5);
        base = upd_total;
        direction = 4'b1010;
        frame(1);
`ifdef BG_SCROLL_DIAG_EN
        check("diag_x", 16'(x_offset), 16'd6);
        check("diag_y", 16'(y_offset), 16'd4);
        check("diag_upd", 16'(upd_total - base), 16'd1);
`else
        check("diag_x", 16'(x_offset), 16'd5);
        check("diag_y", 16'(y_offset), 16'd5);
        check("diag_upd", 16'(upd_total - base), 16'd0);
`endif

        // Collision: freeze for 3 ticks, second collision ignored, then recenter
        direction = 4'b0010;
        collided = 1'b1;
        cyc(1);
        collided = 1'b0;
        cyc(1);
        check("frz_frozen0", 16'(frozen), 16'd1);
        base = upd_total;
        frame(2);
        check("frz_frozen2", 16'(frozen), 16'd1);
        check("frz_hold_upd", 16'(upd_total - base), 16'd0);
        collided = 1'b1;
        cyc(1);
        collided = 1'b0;
        frame(1);
        check("frz_end_frozen", 16'(frozen), 16'd0);
`ifdef BG_SCROLL_DIAG_EN
        check("frz_hold_x", 16'(x_offset), 16'd6);
`else
        check("frz_hold_x", 16'(x_offset), 16'd5);
`endif
        base = upd_total;
        frame(1);
        check("recenter_x", 16'(x_offset), 16'd160);
        check("recenter_y", 16'(y_offset), 16'd120);
        check("recenter_frozen", 16'(frozen), 16'd0);
        check("recenter_upd", 16'(upd_total - base), 16'd1);

        // Back in RUN: right now moves again
        frame(1);
        check("run_after_x", 16'(x_offset), 16'd161);

        // Reset during freeze with frame_clk held high
        collided = 1'b1;
        cyc(1);
        collided = 1'b0;
        cyc(1);
        check("rst2_pre_frozen", 16'(frozen), 16'd1);
        frame_clk = 1'b1;
        cyc(2);
        reset_n = 1'b0;
        cyc(3);
        check("rst2_x", 16'(x_offset), 16'd0);
        check("rst2_y", 16'(y_offset), 16'd0);
        check("rst2_frozen", 16'(frozen), 16'd0);
        check("rst2_upd", 16'(offset_upd), 16'd0);
        reset_n = 1'b1;
        cyc(2);
        // First cycle after release produced no tick, so nothing moved yet.
        check("rel_x", 16'(x_offset), 16'd0);
        check("rel_upd", 16'(offset_upd), 16'd0);
        cyc(1);
        // The synchronized edge then arrives and RUN moves right by one.
        check("rel_late_x", 16'(x_offset), 16'd1);
        check("rel_late_frozen", 16'(frozen), 16'd0);
        frame_clk = 1'b0;
        cyc(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
